// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback encodings and load extraction helpers
package wb_pkg;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wbsel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Works on a 64-bit view so both XLEN builds (and the M-stage path) share it.
  function automatic logic [63:0] ld_extend(input logic [63:0] data,
                                            input logic [2:0]  offset,
                                            input logic [2:0]  funct3);
    logic [63:0] sh;
    sh = data >> {offset, 3'b000};
    case (funct3)
      F3_LB:   ld_extend = {{56{sh[7]}}, sh[7:0]};
      F3_LH:   ld_extend = {{48{sh[15]}}, sh[15:0]};
      F3_LW:   ld_extend = {{32{sh[31]}}, sh[31:0]};
      F3_LBU:  ld_extend = {56'd0, sh[7:0]};
      F3_LHU:  ld_extend = {48'd0, sh[15:0]};
      F3_LWU:  ld_extend = {32'd0, sh[31:0]};
      default: ld_extend = sh;
    endcase
  endfunction

  function automatic logic ld_misaligned(input logic [2:0] offset,
                                         input logic [2:0] funct3,
                                         input logic       is64);
    case (funct3)
      F3_LB, F3_LBU: ld_misaligned = 1'b0;
      F3_LH, F3_LHU: ld_misaligned = offset[0];
      F3_LW:         ld_misaligned = |offset[1:0];
      F3_LWU:        ld_misaligned = !is64 || (|offset[1:0]);
      F3_LD:         ld_misaligned = !is64 || (|offset);
      default:       ld_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rf_array.sv
// rtl/rf_array.sv - register array, one write port, NRP combinational read ports
module rf_array
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : gRead
    logic [AW-1:0] a;
    assign a = raddr[p*AW +: AW];
    assign rdata[p*XLEN +: XLEN] = (a == '0) ? '0 : regs[a];
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select/extend, register file with write-first bypass
module wb_regfile
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int AW   = $clog2(NREG),
  parameter int OW   = $clog2(XLEN/8)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                validW,
  input  logic                regwriteW,
  input  logic [1:0]          wbselW,
  input  logic [2:0]          funct3W,
  input  logic [AW-1:0]       rdW,
  input  logic [XLEN-1:0]     data_readW,
  input  logic                mem_ackW,
  input  logic [XLEN-1:0]     ALUresW,
  input  logic [XLEN-1:0]     pc4W,
  input  logic [XLEN-1:0]     immW,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [XLEN-1:0]     resultW,
  output logic                stallW,
  output logic                lmisalignW,
  output logic [63:0]         instret
);

  localparam logic IS64 = (XLEN == 64);

  logic [2:0]  offset;
  logic        load;
  logic        misaligned;
  logic        retire;
  logic        we;
  logic [XLEN-1:0]     loadData;
  logic [NRP*XLEN-1:0] arrData;
  logic [63:0] instretQ;
  logic        lmisalignQ;
  logic        unusedAluHigh;

  assign offset        = 3'(ALUresW[OW-1:0]);
  assign unusedAluHigh = ^ALUresW[XLEN-1:OW];
  assign loadData      = XLEN'(ld_extend(64'(data_readW), offset, funct3W));

  always_comb begin
    resultW = '0;
    case (wbselW)
      WB_MEM:  resultW = loadData;
      WB_ALU:  resultW = ALUresW;
      WB_PC4:  resultW = pc4W;
      default: resultW = immW;
    endcase
  end

  // Alignment only matters once data actually arrives.
  assign load       = validW && (wbselW == WB_MEM);
  assign stallW     = load && !mem_ackW;
  assign misaligned = load && mem_ackW && ld_misaligned(offset, funct3W, IS64);
  assign retire     = validW && !stallW && !misaligned;
  assign we         = retire && regwriteW && (rdW != '0);

  rf_array #(
    .XLEN(XLEN),
    .NREG(NREG),
    .NRP (NRP),
    .AW  (AW)
  ) uArray (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .waddr(rdW),
    .wdata(resultW),
    .raddr(raddr),
    .rdata(arrData)
  );

  for (genvar p = 0; p < NRP; p++) begin : gBypass
    logic [AW-1:0] a;
    assign a = raddr[p*AW +: AW];
    assign rdata[p*XLEN +: XLEN] = (a == '0)             ? '0      :
                                   (we && a == rdW)      ? resultW :
                                   arrData[p*XLEN +: XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instretQ   <= '0;
      lmisalignQ <= 1'b0;
    end else begin
      instretQ   <= instretQ + {63'd0, retire};
      lmisalignQ <= misaligned;
    end
  end

  assign instret    = instretQ;
  assign lmisalignW = lmisalignQ;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized bench for wb_regfile against a behavioural model
module tb_wb_regfile;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic validW = 1'b0, regwriteW = 1'b0, mem_ackW = 1'b0;
  logic [1:0] wbselW = 2'b01;
  logic [2:0] funct3W = 3'b010;
  logic [AW-1:0] rdW = '0;
  logic [XLEN-1:0] data_readW = '0, ALUresW = '0, pc4W = '0, immW = '0;
  logic [AW-1:0] ra0 = '0, ra1 = '0;
  logic [NRP*XLEN-1:0] rdata;
  logic [XLEN-1:0] resultW;
  logic stallW, lmisalignW;
  logic [63:0] instret;

  int total = 0;
  int bad = 0;

  logic [31:0] mRegs [NREG];
  longint unsigned mInstret = 0;
  logic mStall;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
    .clk(clk), .rst_n(rst_n), .validW(validW), .regwriteW(regwriteW),
    .wbselW(wbselW), .funct3W(funct3W), .rdW(rdW), .data_readW(data_readW),
    .mem_ackW(mem_ackW), .ALUresW(ALUresW), .pc4W(pc4W), .immW(immW),
    .raddr({ra1, ra0}), .rdata(rdata), .resultW(resultW), .stallW(stallW),
    .lmisalignW(lmisalignW), .instret(instret)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int accessBytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00: return 1;
      2'b01: return 2;
      2'b10: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] mdlLoad(input logic [31:0] data, input int off, input logic [2:0] f3);
    longint unsigned v, mask;
    int n;
    n = accessBytes(f3);
    v = longint'(data) / (64'd1 << (8 * off));
    mask = (n == 8) ? ~64'd0 : (64'd1 << (8 * n)) - 1;
    v = v & mask;
    if (f3 < 3'd4 && n < 8 && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic mdlMis(input int off, input logic [2:0] f3);
    if (f3 == 3'b011 || f3 == 3'b110) return 1'b1;
    return (off % accessBytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] mdlResult();
    case (wbselW)
      2'b00: return mdlLoad(data_readW, int'(ALUresW % 4), funct3W);
      2'b01: return ALUresW;
      2'b10: return pc4W;
      default: return immW;
    endcase
  endfunction

  function automatic logic [31:0] mdlRead(input logic [AW-1:0] a, input logic wr, input logic [31:0] res);
    if (a == 0) return 32'd0;
    if (wr && a == rdW) return res;
    return mRegs[a];
  endfunction

  // Called just after a falling edge with inputs already driven; ends on the next falling edge.
  task automatic cycle();
    logic isLoad, mis, retire, wr;
    logic [31:0] res;
    #1;
    isLoad = validW && wbselW == 2'b00;
    mStall = isLoad && !mem_ackW;
    mis    = isLoad && mem_ackW && mdlMis(int'(ALUresW % 4), funct3W);
    retire = validW && !mStall && !mis;
    wr     = retire && regwriteW && rdW != 0;
    res    = mdlResult();
    checkVal("stallW", 64'(stallW), 64'(mStall));
    checkVal("resultW", 64'(resultW), 64'(res));
    checkVal("rdata0", 64'(rdata[31:0]), 64'(mdlRead(ra0, wr, res)));
    checkVal("rdata1", 64'(rdata[63:32]), 64'(mdlRead(ra1, wr, res)));
    @(posedge clk);
    #1;
    if (wr) mRegs[rdW] = res;
    if (retire) mInstret = mInstret + 1;
    checkVal("lmisalignW", 64'(lmisalignW), 64'(mis));
    checkVal("instret", instret, mInstret);
    @(negedge clk);
  endtask

  task automatic setOp(input logic v, input logic rw, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [AW-1:0] rd, input logic ack, input logic [31:0] alu);
    validW = v; regwriteW = rw; wbselW = sel; funct3W = f3; rdW = rd; mem_ackW = ack; ALUresW = alu;
  endtask

  initial begin
    longint unsigned saved;
    logic [2:0] f3;
    for (int i = 0; i < NREG; i++) mRegs[i] = 32'd0;

    // Reset state
    ra0 = 5'd5; ra1 = 5'd31;
    #12;
    checkVal("reset_instret", instret, 64'd0);
    checkVal("reset_lmis", 64'(lmisalignW), 64'd0);
    checkVal("reset_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Select paths and same-cycle bypass
    setOp(1, 1, 2'b01, 3'b010, 5'd5, 0, 32'h2222_2222);
    #1 checkVal("bypass_r5", 64'(rdata[31:0]), 64'h2222_2222);
    cycle();
    pc4W = 32'h3333_3333; immW = 32'h1234_5000;
    setOp(1, 1, 2'b10, 3'b000, 5'd9, 0, 32'h0);
    #1 checkVal("sel_pc4", 64'(resultW), 64'h3333_3333);
    cycle();
    setOp(1, 1, 2'b11, 3'b000, 5'd10, 1, 32'h0);
    #1 checkVal("sel_imm", 64'(resultW), 64'h1234_5000);
    cycle();
    checkVal("array_r5", 64'(rdata[31:0]), 64'h2222_2222);

    // Load extraction
    data_readW = 32'h80FF_7F01;
    setOp(1, 1, 2'b00, 3'b000, 5'd11, 1, 32'h1001);
    #1 checkVal("lb_off1", 64'(resultW), 64'h0000_007F);
    cycle();
    setOp(1, 1, 2'b00, 3'b000, 5'd12, 1, 32'h1002);
    #1 checkVal("lb_off2", 64'(resultW), 64'hFFFF_FFFF);
    cycle();
    setOp(1, 1, 2'b00, 3'b101, 5'd13, 1, 32'h1002);
    #1 checkVal("lhu_off2", 64'(resultW), 64'h0000_80FF);
    cycle();
    setOp(1, 1, 2'b00, 3'b001, 5'd14, 1, 32'h1002);
    #1 checkVal("lh_off2", 64'(resultW), 64'hFFFF_80FF);
    cycle();

    // Stall for three cycles, then ack
    saved = mInstret;
    ra0 = 5'd7;
    data_readW = 32'hCAFE_F00D;
    setOp(1, 1, 2'b00, 3'b010, 5'd7, 0, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      #1 checkVal("stall_hi", 64'(stallW), 64'd1);
      cycle();
    end
    checkVal("stall_nocnt", instret, saved);
    mem_ackW = 1'b1;
    cycle();
    checkVal("stall_write", 64'(rdata[31:0]), 64'hCAFE_F00D);
    checkVal("stall_cnt", instret, saved + 1);

    // Misaligned LW
    saved = mInstret;
    ra0 = 5'd8;
    setOp(1, 1, 2'b00, 3'b010, 5'd8, 1, 32'h1002);
    cycle();
    checkVal("mis_pulse", 64'(lmisalignW), 64'd1);
    checkVal("mis_nowrite", 64'(rdata[31:0]), 64'd0);
    setOp(0, 0, 2'b01, 3'b000, 5'd0, 0, 32'h0);
    cycle();
    checkVal("mis_oneshot", 64'(lmisalignW), 64'd0);
    checkVal("mis_nocnt", instret, saved);

    // x0 write is discarded
    ra0 = 5'd0;
    setOp(1, 1, 2'b01, 3'b000, 5'd0, 0, 32'hDEAD_BEEF);
    #1 checkVal("x0_bypass", 64'(rdata[31:0]), 64'd0);
    cycle();
    checkVal("x0_read", 64'(rdata[31:0]), 64'd0);

    // Counter wrap
    setOp(0, 0, 2'b01, 3'b000, 5'd0, 0, 32'h0);
    force dut.instretQ = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instretQ;
    mInstret = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    setOp(1, 0, 2'b01, 3'b000, 5'd3, 0, 32'h0);
    cycle();
    checkVal("instret_wrap", instret, 64'd0);

    // Randomized traffic; inputs are held while the model says the stage is stalled
    mStall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (mStall) begin
        mem_ackW = ($urandom_range(0, 2) == 0);
      end else begin
        f3 = 3'($urandom_range(0, 6));
        setOp(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), f3,
              AW'($urandom_range(0, NREG - 1)), ($urandom_range(0, 2) != 0), $urandom);
        data_readW = $urandom; pc4W = $urandom; immW = $urandom;
      end
      ra0 = ($urandom_range(0, 3) == 0) ? rdW : AW'($urandom_range(0, NREG - 1));
      ra1 = AW'($urandom_range(0, NREG - 1));
      cycle();
    end

    // Reset asserted in the middle of a stall
    ra0 = 5'd5; ra1 = 5'd7;
    setOp(1, 1, 2'b00, 3'b010, 5'd5, 0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) mRegs[i] = 32'd0;
    mInstret = 0;
    checkVal("rst_mid_instret", instret, 64'd0);
    checkVal("rst_mid_lmis", 64'(lmisalignW), 64'd0);
    checkVal("rst_mid_rdata", 64'(rdata), 64'd0);
    checkVal("rst_mid_stall", 64'(stallW), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    setOp(1, 1, 2'b01, 3'b000, 5'd5, 0, 32'h5555_AAAA);
    cycle();
    checkVal("post_rst_write", 64'(rdata[31:0]), 64'h5555_AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
